// File: rtl/riscy_pkg.sv
// Shared decode definitions: MIPS opcode constants, instruction field
// positions and the decoded_t record carried through the decode stage.
package riscy_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_LSB  = 0;

  // Stored PC width; a stage's PC_W must not exceed this.
  localparam int PC_MAX_W = 32;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [5:0]          opcode;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [4:0]          shamt;
    logic [5:0]          funct;
    logic [15:0]         imm;
    logic [25:0]         jaddr;
    logic                is_rtype;
    logic                is_jump;
  } decoded_t;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational slice of a 32-bit MIPS instruction word (plus its PC)
// into the decoded_t record.
module instr_field_split
  import riscy_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [PC_MAX_W-1:0] pc,
  output decoded_t            fields
);

  // Field extraction and opcode class flags
  always_comb begin
    fields          = '0;
    fields.pc       = pc;
    fields.opcode   = instr[OPCODE_LSB +: 6];
    fields.rs       = instr[RS_LSB +: 5];
    fields.rt       = instr[RT_LSB +: 5];
    fields.rd       = instr[RD_LSB +: 5];
    fields.shamt    = instr[SHAMT_LSB +: 5];
    fields.funct    = instr[FUNCT_LSB +: 6];
    fields.imm      = instr[IMM_LSB +: 16];
    fields.jaddr    = instr[JADDR_LSB +: 26];
    fields.is_rtype = (instr[OPCODE_LSB +: 6] == OP_RTYPE);
    fields.is_jump  = is_jump_op(instr[OPCODE_LSB +: 6]);
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Fetch-to-decode pipeline register with valid/ready handshake and flush.
// Optional skid entry with registered in_ready when DECODE_SKID_BUF_EN is defined.
module instr_decode_stage
  import riscy_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [15:0]     out_imm,
  output logic [25:0]     out_jaddr,
  output logic            out_is_rtype,
  output logic            out_is_jump
);

  decoded_t dec_s;
  decoded_t main_r;
  decoded_t main_n;
  logic     main_valid_r;
  logic     main_valid_n;
  logic     in_xfer_s;
  logic     out_xfer_s;

  instr_field_split u_split (
    .instr  (in_instr),
    .pc     (PC_MAX_W'(in_pc)),
    .fields (dec_s)
  );

  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = main_valid_r && out_ready;

`ifdef DECODE_SKID_BUF_EN
  decoded_t skid_r;
  decoded_t skid_n;
  logic     skid_valid_r;
  logic     skid_valid_n;
  logic     in_ready_r;

  assign in_ready = in_ready_r;

  // Next-state for main and skid entries; a stalled main diverts input to skid
  always_comb begin
    main_n       = main_r;
    main_valid_n = main_valid_r;
    skid_n       = skid_r;
    skid_valid_n = skid_valid_r;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (main_valid_r && !out_xfer_s) begin
      if (in_xfer_s) begin
        skid_n       = dec_s;
        skid_valid_n = 1'b1;
      end else begin
        skid_valid_n = skid_valid_r;
      end
    end else if (skid_valid_r) begin
      // in_ready is low while skid is full, so no input competes here
      main_n       = skid_r;
      main_valid_n = 1'b1;
      skid_valid_n = 1'b0;
    end else if (in_xfer_s) begin
      main_n       = dec_s;
      main_valid_n = 1'b1;
    end else begin
      main_valid_n = 1'b0;
    end
  end

  // Skid entry and registered ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_r       <= '0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      skid_r       <= skid_n;
      skid_valid_r <= skid_valid_n;
      in_ready_r   <= !skid_valid_n;
    end
  end
`else
  assign in_ready = out_ready || !main_valid_r;

  // Next-state for the single entry
  always_comb begin
    main_n       = main_r;
    main_valid_n = main_valid_r;
    if (flush) begin
      main_valid_n = 1'b0;
    end else if (in_xfer_s) begin
      main_n       = dec_s;
      main_valid_n = 1'b1;
    end else if (out_xfer_s) begin
      main_valid_n = 1'b0;
    end else begin
      main_valid_n = main_valid_r;
    end
  end
`endif

  // Main register; reset clears data so every output reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_r       <= '0;
      main_valid_r <= 1'b0;
    end else begin
      main_r       <= main_n;
      main_valid_r <= main_valid_n;
    end
  end

  assign out_valid    = main_valid_r;
  assign out_pc       = main_r.pc[PC_W-1:0];
  assign out_opcode   = main_r.opcode;
  assign out_rs       = main_r.rs;
  assign out_rt       = main_r.rt;
  assign out_rd       = main_r.rd;
  assign out_shamt    = main_r.shamt;
  assign out_funct    = main_r.funct;
  assign out_imm      = main_r.imm;
  assign out_jaddr    = main_r.jaddr;
  assign out_is_rtype = main_r.is_rtype;
  assign out_is_jump  = main_r.is_jump;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus a
// randomized run against a FIFO-occupancy reference model.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm;
  logic [25:0] out_jaddr;
  logic        out_is_rtype;
  logic        out_is_jump;

`ifdef DECODE_SKID_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t q[$];
  int checks = 0;
  int failures = 0;
  int acc_dut = 0;

  instr_decode_stage #(.PC_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_opcode   (out_opcode),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_shamt    (out_shamt),
    .out_funct    (out_funct),
    .out_imm      (out_imm),
    .out_jaddr    (out_jaddr),
    .out_is_rtype (out_is_rtype),
    .out_is_jump  (out_is_jump)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ready as seen from outside: skid build accepts while fewer than 2 held,
  // single-entry build accepts when empty or when the held one leaves now.
  function automatic logic exp_ready(input logic ordy);
    if (CAP == 2) return q.size() < 2;
    else return (q.size() == 0) || ordy;
  endfunction

  task automatic compare_front();
    int unsigned w;
    int unsigned op;
    w  = q[0].instr;
    op = w >> 26;
    check("pc",       out_pc,       q[0].pc);
    check("opcode",   out_opcode,   op);
    check("rs",       out_rs,       (w >> 21) % 32);
    check("rt",       out_rt,       (w >> 16) % 32);
    check("rd",       out_rd,       (w >> 11) % 32);
    check("shamt",    out_shamt,    (w >> 6) % 32);
    check("funct",    out_funct,    w % 64);
    check("imm",      out_imm,      w % 65536);
    check("jaddr",    out_jaddr,    w % 67108864);
    check("is_rtype", out_is_rtype, op == 0);
    check("is_jump",  out_is_jump,  (op == 2) || (op == 3));
  endtask

  // One cycle: drive at negedge, check against model, advance model, clock.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                      input logic ordy, input logic fl);
    logic acc;
    logic pop;
    in_valid  = v;
    in_instr  = w;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    #1;
    check("in_ready", in_ready, exp_ready(ordy));
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) compare_front();
    if (v && in_ready) acc_dut++;
    acc = v && exp_ready(ordy);
    pop = (q.size() != 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{instr: w, pc: p});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [31:0] sext;

    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_opcode", out_opcode, 6'h0);
    check("rst_imm", out_imm, 16'h0);
    check("rst_jaddr", out_jaddr, 26'h0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // addi $t0,$t1,-4
    step(1'b1, 32'h2128FFFC, 32'h0000_0040, 1'b1, 1'b0);
    check("addi_valid", out_valid, 1'b1);
    check("addi_opcode", out_opcode, 6'h08);
    check("addi_rs", out_rs, 5'd9);
    check("addi_rt", out_rt, 5'd8);
    check("addi_imm", out_imm, 16'hFFFC);
    check("addi_rtype", out_is_rtype, 1'b0);
    sext = {{16{out_imm[15]}}, out_imm};
    check("addi_sext", sext, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // back-to-back stream, one NOP included
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 3) ? 32'h0 : $urandom, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      if (out_valid) n++;
    end
    check("stream_out_cycles", n, 8);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // stall with input pending
    acc_dut = 0;
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    check("hold_accepts", acc_dut, CAP);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush with entries held and input offered
    step(1'b1, $urandom, 32'h300, 1'b0, 1'b0);
    step(1'b1, $urandom, 32'h304, 1'b0, 1'b0);
    step(1'b1, $urandom, 32'h308, 1'b0, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // jal then add
    step(1'b1, 32'h0C00_0123, 32'h400, 1'b1, 1'b0);
    check("jal_is_jump", out_is_jump, 1'b1);
    check("jal_jaddr", out_jaddr, 26'h0000123);
    step(1'b1, 32'h0122_5020, 32'h404, 1'b1, 1'b0);
    check("add_is_rtype", out_is_rtype, 1'b1);
    check("add_rd", out_rd, 5'd10);
    check("add_funct", out_funct, 6'h20);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset between edges with data held
    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_opcode", out_opcode, 6'h0);
    check("arst_rs", out_rs, 5'h0);
    check("arst_funct", out_funct, 6'h0);
    check("arst_imm", out_imm, 16'h0);
    check("arst_jaddr", out_jaddr, 26'h0);
    check("arst_jump", out_is_jump, 1'b0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1,
           ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
           $urandom,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
